// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - half-duplex serial port sequencer driving an 8-bit universal shift register
// TX loads a handshaken word and shifts it out; RX shifts W bits in and offers the word on valid/ready.

module shift_seq_ctrl #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         tx_valid_i,
   input  logic [W-1:0] tx_data_i,
   output logic         tx_ready_o,
   input  logic         rx_en_i,
   input  logic         sd_i,
   output logic         sd_o,
   output logic         sd_valid_o,
   output logic         rx_valid_o,
   output logic [W-1:0] rx_data_o,
   input  logic         rx_ready_i,
   output logic         busy_o,
   output logic [1:0]   sr_mode_o,
   output logic         sr_d_o,
   output logic [W-1:0] sr_par_o,
   input  logic [W-1:0] sr_p_i
);

   localparam int CW = $clog2(W + 1);
   localparam logic [1:0] MODE_HOLD  = 2'd0;
   localparam logic [1:0] MODE_LOAD  = 2'd1;
   localparam logic [1:0] MODE_SHIFT = MSB_FIRST ? 2'd2 : 2'd3;
   localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_TX_SHIFT,
      S_RX_SHIFT,
      S_RX_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  par_q;
   logic          tap;

   // The bit leaving the register first is the one the serial line carries.
   assign tap = MSB_FIRST ? sr_p_i[W-1] : sr_p_i[0];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE;
         cnt   <= '0;
         par_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (tx_valid_i) begin
                  par_q <= tx_data_i;
                  state <= S_LOAD;
               end else if (rx_en_i) begin
                  cnt   <= '0;
                  state <= S_RX_SHIFT;
               end
            end
            S_LOAD: begin
               cnt   <= '0;
               state <= S_TX_SHIFT;
            end
            S_TX_SHIFT: begin
               if (cnt == LAST_BIT) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RX_SHIFT: begin
               if (cnt == LAST_BIT) begin
                  cnt   <= '0;
                  state <= S_RX_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RX_DONE: begin
               if (rx_ready_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_ready_o = 1'b0;
      sd_o       = 1'b0;
      sd_valid_o = 1'b0;
      rx_valid_o = 1'b0;
      rx_data_o  = '0;
      busy_o     = (state != S_IDLE);
      sr_mode_o  = MODE_HOLD;
      sr_d_o     = 1'b0;
      sr_par_o   = '0;
      case (state)
         S_IDLE:     tx_ready_o = 1'b1;
         S_LOAD: begin
            sr_mode_o = MODE_LOAD;
            sr_par_o  = par_q;
         end
         S_TX_SHIFT: begin
            sr_mode_o  = MODE_SHIFT;
            sd_o       = tap;
            sd_valid_o = 1'b1;
         end
         S_RX_SHIFT: begin
            sr_mode_o = MODE_SHIFT;
            sr_d_o    = sd_i;
         end
         S_RX_DONE: begin
            rx_valid_o = 1'b1;
            rx_data_o  = sr_p_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - bench for shift_seq_ctrl, MSB-first and LSB-first instances side by side
// Both instances share stimulus; each drives its own behavioural shift register.

module tb_shift_seq_ctrl;

   localparam int W = 8;

   logic tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   logic         nrst, tx_valid, rx_en, sd_in, rx_ready;
   logic [W-1:0] tx_data;

   logic         a_tx_ready, a_sd, a_sd_valid, a_rx_valid, a_busy, a_srd;
   logic [W-1:0] a_rx_data, a_par, a_p;
   logic [1:0]   a_mode;
   logic         b_tx_ready, b_sd, b_sd_valid, b_rx_valid, b_busy, b_srd;
   logic [W-1:0] b_rx_data, b_par, b_p;
   logic [1:0]   b_mode;

   int total = 0;
   int bad   = 0;

   shift_seq_ctrl #(.W(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(tb_clk), .nrst(nrst), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
      .tx_ready_o(a_tx_ready), .rx_en_i(rx_en), .sd_i(sd_in), .sd_o(a_sd),
      .sd_valid_o(a_sd_valid), .rx_valid_o(a_rx_valid), .rx_data_o(a_rx_data),
      .rx_ready_i(rx_ready), .busy_o(a_busy), .sr_mode_o(a_mode), .sr_d_o(a_srd),
      .sr_par_o(a_par), .sr_p_i(a_p)
   );

   shift_seq_ctrl #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(tb_clk), .nrst(nrst), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
      .tx_ready_o(b_tx_ready), .rx_en_i(rx_en), .sd_i(sd_in), .sd_o(b_sd),
      .sd_valid_o(b_sd_valid), .rx_valid_o(b_rx_valid), .rx_data_o(b_rx_data),
      .rx_ready_i(rx_ready), .busy_o(b_busy), .sr_mode_o(b_mode), .sr_d_o(b_srd),
      .sr_par_o(b_par), .sr_p_i(b_p)
   );

   // Universal shift registers the controllers drive.
   always_ff @(posedge tb_clk or negedge nrst) begin
      if (!nrst) a_p <= '0;
      else case (a_mode)
         2'd1:    a_p <= a_par;
         2'd2:    a_p <= {a_p[W-2:0], a_srd};
         2'd3:    a_p <= {a_srd, a_p[W-1:1]};
         default: a_p <= a_p;
      endcase
   end

   always_ff @(posedge tb_clk or negedge nrst) begin
      if (!nrst) b_p <= '0;
      else case (b_mode)
         2'd1:    b_p <= b_par;
         2'd2:    b_p <= {b_p[W-2:0], b_srd};
         2'd3:    b_p <= {b_srd, b_p[W-1:1]};
         default: b_p <= b_p;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk(tag, 32'({a_tx_ready, b_tx_ready, a_sd, b_sd, a_sd_valid, b_sd_valid,
                    a_rx_valid, b_rx_valid, a_busy, b_busy, a_srd, b_srd}), 32'h0C00);
      chk({tag, "_bus"}, 32'({a_mode, b_mode, a_rx_data, b_rx_data}), 32'd0);
      chk({tag, "_par"}, 32'({a_par, b_par}), 32'd0);
   endtask

   // Called just after a negedge with both controllers idle; returns at the idle negedge after the word.
   task automatic do_tx(input logic [W-1:0] w, input bit hold, input logic [W-1:0] nxt);
      tx_valid = 1'b1;
      tx_data  = w;
      chk("tx_ready_idle", 32'({a_tx_ready, b_tx_ready}), 32'd3);
      @(negedge tb_clk);
      if (hold) tx_data = nxt;
      else tx_valid = 1'b0;
      chk("load_mode", 32'({a_mode, b_mode}), 32'h5);
      chk("load_par", 32'({a_par, b_par}), 32'({w, w}));
      chk("load_ready_busy", 32'({a_tx_ready, b_tx_ready, a_busy, b_busy}), 32'h3);
      for (int i = 0; i < W; i++) begin
         @(negedge tb_clk);
         rx_ready = 1'($urandom);
         chk("tx_mode", 32'({a_mode, b_mode}), 32'hB);
         chk("tx_flags", 32'({a_sd_valid, b_sd_valid, a_tx_ready, b_tx_ready, a_srd, b_srd}), 32'h30);
         chk("tx_bit_msb", 32'(a_sd), 32'((w >> (W - 1 - i)) & 1));
         chk("tx_bit_lsb", 32'(b_sd), 32'((w >> i) & 1));
      end
      @(negedge tb_clk);
      rx_ready = 1'b0;
      chk("tx_end", 32'({a_tx_ready, b_tx_ready, a_busy, b_busy, a_sd_valid, b_sd_valid, a_sd, b_sd}), 32'hC0);
   endtask

   // s[i] is the i-th bit placed on the line.
   task automatic do_rx(input logic [W-1:0] s, input int dly);
      logic [W-1:0] em, el;
      em = '0;
      el = '0;
      for (int i = 0; i < W; i++) begin
         em = em | (W'(s[i]) << (W - 1 - i));
         el = el | (W'(s[i]) << i);
      end
      rx_en    = 1'b1;
      rx_ready = 1'b0;
      chk("rx_idle_ready", 32'({a_tx_ready, b_tx_ready}), 32'd3);
      @(negedge tb_clk);
      rx_en = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i > 0) @(negedge tb_clk);
         chk("rx_mode", 32'({a_mode, b_mode, a_rx_valid, b_rx_valid, a_sd_valid}), 32'h58);
         sd_in = s[i];
         #1;
         chk("rx_passthru", 32'({a_srd, b_srd}), 32'({s[i], s[i]}));
      end
      @(negedge tb_clk);
      for (int k = 0; k <= dly; k++) begin
         if (k > 0) @(negedge tb_clk);
         chk("rx_valid", 32'({a_rx_valid, b_rx_valid, a_busy, b_busy, a_mode, b_mode}), 32'hF0);
         chk("rx_data_msb", 32'(a_rx_data), 32'(em));
         chk("rx_data_lsb", 32'(b_rx_data), 32'(el));
      end
      rx_ready = 1'b1;
      @(negedge tb_clk);
      rx_ready = 1'b0;
      chk("rx_end", 32'({a_rx_valid, b_rx_valid, a_busy, b_busy, a_tx_ready, b_tx_ready}), 32'h3);
      chk("rx_data_idle", 32'({a_rx_data, b_rx_data}), 32'd0);
   endtask

   initial begin
      logic [W-1:0] rw, rs;
      nrst     = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      rx_en    = 1'b0;
      sd_in    = 1'b0;
      rx_ready = 1'b0;

      @(negedge tb_clk);
      chk_reset_outs("reset_c0");
      @(negedge tb_clk);
      chk_reset_outs("reset_c1");
      nrst     = 1'b1;
      tx_valid = 1'b0;
      #1;
      chk_reset_outs("reset_release");

      do_tx(8'hA5, 1'b0, '0);
      do_rx(8'h55, 3);
      do_tx(8'h01, 1'b0, '0);

      // TX wins over a simultaneous RX request; a held word waits for IDLE.
      rx_en = 1'b1;
      do_tx(8'h3C, 1'b1, 8'hFF);
      do_tx(8'hFF, 1'b0, '0);
      do_rx(8'h55, 0);

      tx_valid = 1'b1;
      tx_data  = 8'hF0;
      @(negedge tb_clk);
      tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge tb_clk);
         chk("midrst_bit", 32'({a_sd_valid, a_sd}), 32'({1'b1, 1'(8'hF0 >> (W - 1 - i))}));
      end
      @(negedge tb_clk);
      nrst = 1'b0;
      #1;
      chk_reset_outs("midrst");
      chk("midrst_sr", 32'({a_p, b_p}), 32'd0);
      @(negedge tb_clk);
      nrst = 1'b1;
      #1;
      chk("midrst_release", 32'({a_tx_ready, b_tx_ready, a_busy, b_busy}), 32'hC);
      do_tx(8'h81, 1'b0, '0);

      for (int n = 0; n < 8; n++) begin
         rw = 8'($urandom);
         rs = 8'($urandom);
         if (($urandom % 2) == 0) begin
            do_tx(rw, 1'b0, '0);
            do_rx(rs, $urandom_range(0, 3));
         end else begin
            do_rx(rs, $urandom_range(0, 3));
            do_tx(rw, 1'b0, '0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
